// File: rtl/sram_rw_port_initiator.sv
// Ready/valid front end for a single-port RW0 SRAM macro: issues reads and
// byte-masked writes, and returns read data in order through a small response FIFO.
module sram_rw_port_initiator #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MASK_W     = DATA_W / 8,
    parameter int RESP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,

    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata,

    output logic              idle
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic              rd_pend;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];

    logic              req_fire;
    logic              resp_fire;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A read in flight already owns a FIFO slot, so credit counts it alongside stored entries.
    assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, rd_pend};
    assign resp_valid = rd_pend || (count != '0);
    assign resp_fire  = resp_valid && resp_ready;
    assign req_ready  = (occupancy < (CNT_W + 1)'(RESP_DEPTH)) || resp_fire;
    assign req_fire   = req_valid && req_ready;

    assign push = rd_pend;
    assign pop  = resp_fire;

    // With an empty FIFO the arriving SRAM word is presented directly, giving one-cycle latency.
    assign resp_rdata = (count == '0) ? RW0_rdata : fifo_mem[rd_ptr];
    assign idle       = !rd_pend && (count == '0) && !resp_valid;

    assign RW0_en    = req_fire;
    assign RW0_wmode = req_write;
    assign RW0_addr  = req_addr;
    assign RW0_wdata = req_wdata;
    assign RW0_wmask = req_write ? req_wmask : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            rd_pend <= req_fire && !req_write;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= RW0_rdata;
    end

    overflow_check: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && (count == CNT_W'(RESP_DEPTH)) && !resp_fire));

endmodule

// File: tb/tb_sram_rw_port_initiator.sv
// Bench for sram_rw_port_initiator: a behavioural SRAM macro, a scoreboard monitor
// driven by a reference memory, and directed plus randomized scenarios.
module tb_sram_rw_port_initiator;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int DEPTH  = 2;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [MASK_W-1:0] req_wmask;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid, resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              RW0_en, RW0_wmode;
    logic [ADDR_W-1:0] RW0_addr;
    logic [MASK_W-1:0] RW0_wmask;
    logic [DATA_W-1:0] RW0_wdata, RW0_rdata;
    logic              idle;

    int n_vec = 0;
    int n_err = 0;

    sram_rw_port_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RESP_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr),
        .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata),
        .idle(idle)
    );

    always #5 clock = ~clock;

    // Behavioural SRAM macro: registered read data, garbage on cycles without a read.
    logic [DATA_W-1:0] sram [1 << ADDR_W];
    always @(posedge clock) begin
        if (RW0_en && RW0_wmode) begin
            for (int i = 0; i < MASK_W; i++)
                if (RW0_wmask[i]) sram[RW0_addr][i*8 +: 8] <= RW0_wdata[i*8 +: 8];
        end
        if (RW0_en && !RW0_wmode) RW0_rdata <= sram[RW0_addr];
        else                      RW0_rdata <= $urandom();
    end

    // Reference model: memory contents in request order plus a queue of expected responses.
    logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
    logic [DATA_W-1:0] exp_q [$];

    always @(negedge clock) begin
        logic exp_valid, exp_ready, exp_fire;
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            exp_valid = (exp_q.size() > 0);
            exp_ready = (exp_q.size() < DEPTH) || (exp_valid && resp_ready);
            exp_fire  = req_valid && exp_ready;
            n_vec++; if (resp_valid !== exp_valid) begin n_err++; $display("FAIL mon_resp_valid: got %b want %b", resp_valid, exp_valid); end
            n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL mon_req_ready: got %b want %b", req_ready, exp_ready); end
            n_vec++; if (idle !== !exp_valid) begin n_err++; $display("FAIL mon_idle: got %b want %b", idle, !exp_valid); end
            n_vec++; if (RW0_en !== exp_fire) begin n_err++; $display("FAIL mon_rw0_en: got %b want %b", RW0_en, exp_fire); end
            if (exp_fire) begin
                n_vec++;
                if (RW0_wmode !== req_write || RW0_addr !== req_addr ||
                    RW0_wmask !== (req_write ? req_wmask : 4'h0) || (req_write && RW0_wdata !== req_wdata)) begin
                    n_err++;
                    $display("FAIL mon_rw0_drive: got wmode=%b addr=%h mask=%h data=%h want wmode=%b addr=%h mask=%h data=%h",
                             RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata, req_write, req_addr,
                             req_write ? req_wmask : 4'h0, req_wdata);
                end
            end
            if (exp_valid && resp_ready) begin
                n_vec++; if (resp_rdata !== exp_q[0]) begin n_err++; $display("FAIL mon_resp_rdata: got %h want %h", resp_rdata, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            if (exp_fire) begin
                if (req_write) begin
                    for (int i = 0; i < MASK_W; i++)
                        if (req_wmask[i]) ref_mem[req_addr][i*8 +: 8] = req_wdata[i*8 +: 8];
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d, input logic rr);
        req_valid = v; req_write = w; req_addr = a; req_wmask = m; req_wdata = d; resp_ready = rr;
        #1;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_vec++; if (RW0_en !== 1'b0) begin n_err++; $display("FAIL reset_rw0_en: got %b want 0", RW0_en); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        repeat (3) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 1'b1);
        n_vec++; if (RW0_wmask !== 4'hF || RW0_wmode !== 1'b1) begin n_err++; $display("FAIL wr_drive: got mask=%h wmode=%b want F 1", RW0_wmask, RW0_wmode); end
        tick();
        drive(1'b1, 1'b0, 10'd5, 4'hF, 32'h0, 1'b1);
        n_vec++; if (RW0_wmask !== 4'h0 || RW0_en !== 1'b1) begin n_err++; $display("FAIL rd_mask_forced: got mask=%h en=%b want 0 1", RW0_wmask, RW0_en); end
        tick();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd_latency: got v=%b d=%h want 1 deadbeef", resp_valid, resp_rdata); end
        tick();
    endtask

    task automatic test_partial_write();
        drive(1'b1, 1'b1, 10'd7, 4'hF, 32'hAABBCCDD, 1'b1); tick();
        drive(1'b1, 1'b1, 10'd7, 4'b0101, 32'h11223344, 1'b1); tick();
        drive(1'b1, 1'b0, 10'd7, 4'h0, 32'h0, 1'b1); tick();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hAA22CC44) begin n_err++; $display("FAIL partial_write: got v=%b d=%h want 1 aa22cc44", resp_valid, resp_rdata); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] d [3];
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom();
            drive(1'b1, 1'b1, ADDR_W'(20 + i), 4'hF, d[i], 1'b1); tick();
        end
        drive(1'b1, 1'b0, 10'd20, 4'h0, 32'h0, 1'b0);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_1st: got %b want 1", req_ready); end
        tick();
        drive(1'b1, 1'b0, 10'd21, 4'h0, 32'h0, 1'b0);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_2nd: got %b want 1", req_ready); end
        tick();
        drive(1'b1, 1'b0, 10'd22, 4'h0, 32'h0, 1'b0);
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_3rd: got %b want 0", req_ready); end
        tick();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== d[0]) begin n_err++; $display("FAIL bp_hold: got v=%b d=%h want 1 %h", resp_valid, resp_rdata, d[0]); end
        tick();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        n_vec++; if (resp_rdata !== d[0]) begin n_err++; $display("FAIL bp_drain0: got %h want %h", resp_rdata, d[0]); end
        tick();
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== d[1]) begin n_err++; $display("FAIL bp_drain1: got v=%b d=%h want 1 %h", resp_valid, resp_rdata, d[1]); end
        tick();
        n_vec++; if (resp_valid !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL bp_no_dup: got v=%b idle=%b want 0 1", resp_valid, idle); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] vals [16];
        for (int i = 0; i < 16; i++) begin
            vals[i] = $urandom();
            drive(1'b1, 1'b1, ADDR_W'(100 + i), 4'hF, vals[i], 1'b1); tick();
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, ADDR_W'(100 + i), 4'h0, 32'h0, 1'b1);
            n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); end
            if (i > 0) begin
                n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== vals[i-1]) begin n_err++; $display("FAIL b2b_data[%0d]: got v=%b d=%h want 1 %h", i - 1, resp_valid, resp_rdata, vals[i-1]); end
            end
            tick();
        end
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== vals[15]) begin n_err++; $display("FAIL b2b_data[15]: got v=%b d=%h want 1 %h", resp_valid, resp_rdata, vals[15]); end
        tick();
    endtask

    task automatic test_read_then_write();
        drive(1'b1, 1'b1, 10'd9, 4'hF, 32'h1, 1'b1); tick();
        drive(1'b1, 1'b0, 10'd9, 4'h0, 32'h0, 1'b1); tick();
        drive(1'b1, 1'b1, 10'd9, 4'hF, 32'h2, 1'b1);
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h1) begin n_err++; $display("FAIL rtw_old: got v=%b d=%h want 1 00000001", resp_valid, resp_rdata); end
        tick();
        drive(1'b1, 1'b0, 10'd9, 4'h0, 32'h0, 1'b1); tick();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h2) begin n_err++; $display("FAIL wtr_new: got v=%b d=%h want 1 00000002", resp_valid, resp_rdata); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom()), ADDR_W'($urandom_range(0, 7)),
                  4'($urandom()), $urandom(), 1'($urandom_range(0, 3) != 0));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, '0, '0, '0, 1'b1); tick();
        end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL rand_drained: got idle=%b want 1", idle); end
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, 1'b0, 10'd9, 4'h0, 32'h0, 1'b1); tick();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        reset_n = 1'b0; #1;
        n_vec++; if (resp_valid !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL rst_mid_read: got v=%b idle=%b want 0 1", resp_valid, idle); end
        @(negedge clock);
        @(posedge clock); #3 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_resp[%0d]: got %b want 0", i, resp_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_write_read();
        test_partial_write();
        test_backpressure();
        test_back_to_back();
        test_read_then_write();
        test_random();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
